// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcode, funct and mnemonic codes
package mips_pkg;
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD    = 6'b100000;
  localparam logic [5:0] FN_SUB    = 6'b100010;
  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_ADD    = 4'd1;
  localparam logic [3:0] OP_SUB    = 4'd2;
  localparam logic [3:0] OP_ORI    = 4'd3;
  localparam logic [3:0] OP_LW     = 4'd4;
  localparam logic [3:0] OP_SW     = 4'd5;
  localparam logic [3:0] OP_LUI    = 4'd6;
  localparam logic [3:0] OP_BEQ    = 4'd7;
  localparam logic [3:0] OP_JAL    = 4'd8;
  localparam logic [3:0] OP_JR     = 4'd9;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with wrap-bit pointers for full/empty detection
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  // storage is cleared on reset so the head word reads as zero afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: assembles MIPS machine words from symbolic ops and streams them with IM addresses
module instr_encoder
  import mips_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          IM_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] count
);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'((IM_WORDS - 1) * 4);
  logic full, empty, legal, accept, pop;
  logic [31:0] word;
  assign in_ready = !reset && !full;
  assign legal = in_op <= OP_JR;
  assign accept = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  // field packing; unused fields stay zero and illegal/NOP codes give an all-zero word
  always_comb begin
    word = '0;
    case (in_op)
      OP_ADD: word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_ADD};
      OP_SUB: word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SUB};
      OP_ORI: word = {OPC_ORI, in_rs, in_rt, in_imm};
      OP_LW:  word = {OPC_LW, in_rs, in_rt, in_imm};
      OP_SW:  word = {OPC_SW, in_rs, in_rt, in_imm};
      OP_LUI: word = {OPC_LUI, 5'd0, in_rt, in_imm};
      OP_BEQ: word = {OPC_BEQ, in_rs, in_rt, in_imm};
      OP_JAL: word = {OPC_JAL, in_target};
      OP_JR:  word = {OPC_RTYPE, in_rs, 15'd0, FN_JR};
      default: word = '0;
    endcase
  end
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(accept && legal),
    .pop(pop),
    .din(word),
    .dout(out_instr),
    .full(full),
    .empty(empty)
  );
  // address wraps at the end of instruction memory, count saturates, err flags an accepted illegal op
  always_ff @(posedge clk) begin
    if (reset) begin
      out_addr <= BASE_ADDR;
      count <= '0;
      err <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (pop) begin
        out_addr <= (out_addr == LAST_ADDR) ? BASE_ADDR : out_addr + 32'd4;
        count <= (count == 16'hFFFF) ? count : count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a reference model
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_3000;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [3:0] in_op = 0;
  logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0;
  logic [15:0] in_imm = 0;
  logic [25:0] in_target = 0;
  logic in_ready, out_valid, err, in_ready4, out_valid4, err4;
  logic [31:0] out_instr, out_addr, out_instr4, out_addr4;
  logic [15:0] count, count4;
  logic [31:0] q[$];
  int emitted = 0, cnt = 0, n_cmp = 0, n_err = 0;
  logic exp_err = 0;
  bit last_acc;

  instr_encoder #(.DEPTH(DEPTH), .IM_WORDS(1024), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .count(count));
  instr_encoder #(.DEPTH(DEPTH), .IM_WORDS(4), .BASE_ADDR(BASE)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4), .out_addr(out_addr4),
    .err(err4), .count(count4));

  always #5 clk = ~clk;

  function automatic logic [31:0] model_encode(input longint op, rs, rt, rd, imm, tgt);
    longint r, i, t;
    r = rs * 2**21 + rt * 2**16;
    i = 2**26;
    case (op)
      1: t = r + rd * 2**11 + 32;
      2: t = r + rd * 2**11 + 34;
      3: t = 13 * i + r + imm;
      4: t = 35 * i + r + imm;
      5: t = 43 * i + r + imm;
      6: t = 15 * i + rt * 2**16 + imm;
      7: t = 4 * i + r + imm;
      8: t = 3 * i + tgt;
      9: t = rs * 2**21 + 8;
      default: t = 0;
    endcase
    return 32'(t);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input int op, input int rs, input int rt, input int rd, input int imm, input int tgt);
    in_valid = 1;
    in_op = 4'(op);
    in_rs = 5'(rs);
    in_rt = 5'(rt);
    in_rd = 5'(rd);
    in_imm = 16'(imm);
    in_target = 26'(tgt);
  endtask

  task automatic tick();
    bit rdy, ov, acc, pp;
    #1;
    rdy = !reset && q.size() < DEPTH;
    ov = q.size() > 0;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("in_ready4", 32'(in_ready4), 32'(rdy));
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("out_valid4", 32'(out_valid4), 32'(ov));
    if (ov) begin
      chk("out_instr", out_instr, q[0]);
      chk("out_instr4", out_instr4, q[0]);
      chk("out_addr", out_addr, BASE + 32'(4 * (emitted % 1024)));
      chk("out_addr_wrap4", out_addr4, BASE + 32'(4 * (emitted % 4)));
    end
    acc = in_valid && rdy;
    pp = ov && out_ready;
    last_acc = acc;
    @(posedge clk);
    if (reset) begin
      q.delete();
      emitted = 0;
      cnt = 0;
      exp_err = 0;
    end else begin
      if (pp) begin
        void'(q.pop_front());
        emitted++;
        if (cnt < 65535) cnt++;
      end
      if (acc && in_op <= 9)
        q.push_back(model_encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target));
      exp_err = acc && in_op > 9;
    end
    @(negedge clk);
    chk("err", 32'(err), 32'(exp_err));
    chk("err4", 32'(err4), 32'(exp_err));
    chk("count", 32'(count), 32'(cnt));
    chk("count4", 32'(count4), 32'(cnt));
  endtask

  task automatic do_reset();
    reset = 1;
    in_valid = 0;
    tick();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    reset = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_count", 32'(count), 0);
    chk("rst_err", 32'(err), 0);
    chk("rel_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    // single ADD
    out_ready = 1;
    set_in(1, 1, 2, 3, 0, 0);
    tick();
    in_valid = 0;
    chk("add_word", out_instr, 32'h0022_1820);
    chk("add_addr", out_addr, BASE);
    tick();
    // back-to-back stream
    do_reset();
    set_in(3, 1, 1, 0, 16'h1234, 0); tick();
    set_in(6, 5, 2, 0, 16'hFFFF, 0); tick();
    set_in(8, 0, 0, 0, 0, 26'h0000C03); tick();
    set_in(9, 31, 0, 0, 0, 0); tick();
    set_in(0, 7, 7, 7, 16'hFFFF, 26'h3FFFFFF); tick();
    in_valid = 0;
    repeat (6) tick();
    chk("stream_count", 32'(count), 5);
    chk("stream_addr", out_addr, BASE + 32'd20);
    // back-pressure
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_in(1 + i, i, i + 1, i + 2, i * 3, 0);
      tick();
    end
    chk("full_in_ready", 32'(in_ready), 0);
    set_in(7, 3, 4, 0, 16'h0010, 0);
    tick();
    out_ready = 1;
    for (int i = 0; i < 10 && !last_acc; i++) tick();
    chk("fifth_accepted", 32'(last_acc), 1);
    in_valid = 0;
    repeat (6) tick();
    // illegal op between legal ones
    set_in(5, 29, 8, 0, 16'hFFFC, 0); tick();
    set_in(12, 1, 2, 3, 16'h5555, 26'h1); tick();
    chk("illegal_err", 32'(err), 1);
    set_in(7, 8, 0, 0, 16'h0003, 0); tick();
    chk("illegal_err_once", 32'(err), 0);
    in_valid = 0;
    repeat (4) tick();
    // reset with queued words
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(4, i, i, 0, i, 0);
      tick();
    end
    reset = 1;
    set_in(2, 1, 1, 1, 0, 0);
    tick();
    reset = 0;
    in_valid = 0;
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_addr", out_addr, BASE);
    out_ready = 1;
    repeat (4) tick();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (8) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
